// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Machine-mode CSR addresses, mstatus/mie bit positions,
//               interrupt cause codes and the trap sequencer state type.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  localparam logic [31:0] CAUSE_EXT_IRQ = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TMR_IRQ = 32'h8000_0007;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SAVE_EPC    = 3'd1,
    SAVE_CAUSE  = 3'd2,
    SAVE_STATUS = 3'd3,
    JUMP        = 3'd4,
    RET_STATUS  = 3'd5,
    RET_JUMP    = 3'd6
  } trap_state_e;

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_if
// Description : CSR file link: single write port driven by the trap
//               sequencer plus the CSR file's registered read-back values.
// Revision    : 1.0 - initial release
// ============================================================================
interface trap_ctrl_if #(
  parameter int DW    = 32,
  parameter int ADDRW = 12
);
  logic             csr_we;
  logic [ADDRW-1:0] csr_addr;
  logic [DW-1:0]    csr_wdata;
  logic             intr_flag;
  logic [DW-1:0]    trap_pc;
  logic [DW-1:0]    mstatus;
  logic [DW-1:0]    mie;
  logic [DW-1:0]    mtvec;
  logic [DW-1:0]    mepc;

  // Trap sequencer side
  modport master (
    output csr_we, csr_addr, csr_wdata, intr_flag, trap_pc,
    input  mstatus, mie, mtvec, mepc
  );

  // CSR file side
  modport slave (
    input  csr_we, csr_addr, csr_wdata, intr_flag, trap_pc,
    output mstatus, mie, mtvec, mepc
  );
endinterface
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync
// Description : Multi-flop level synchronizer for an asynchronous interrupt
//               line, cleared by the asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
  parameter int STAGES = 2
) (
  input  wire logic clk_i,
  input  wire logic rst_i,
  input  wire logic irq_i,
  output logic      irq_s_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw level through the chain; the last flop is the clean copy
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], irq_i};
    end
  end

  assign irq_s_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine-mode interrupt entry / mret sequencer. Saves mepc,
//               mcause and mstatus through the CSR write port, flushes the
//               pipeline and redirects fetch to the handler or back to mepc.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
  import csr_pkg::*;
#(
  parameter int DW          = 32,
  parameter int ADDRW       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  input  wire logic          ext_irq_i,
  input  wire logic          tmr_irq_i,
  input  wire logic [DW-1:0] pc_i,
  input  wire logic          pc_valid_i,
  input  wire logic          csr_instr_i,
  input  wire logic          mret_i,
  trap_ctrl_if.master        csr,
  output logic               flush_o,
  output logic               redirect_o,
  output logic [DW-1:0]      redirect_pc_o,
  output logic               busy_o
);

  trap_state_e   state, state_d;
  logic          ext_s, tmr_s;
  logic          ext_p, tmr_p, take, accept;
  logic [DW-1:0] pc_q;
  logic [31:0]   cause_q;
  logic [DW-1:0] status_trap, status_ret;
  logic [DW-1:0] tvec_base, tvec_target;
  logic          unused_mie;

  irq_sync #(.STAGES(SYNC_STAGES)) u_ext_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .irq_i   (ext_irq_i),
    .irq_s_o (ext_s)
  );

  irq_sync #(.STAGES(SYNC_STAGES)) u_tmr_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .irq_i   (tmr_irq_i),
    .irq_s_o (tmr_s)
  );

  // Only the two enable bits of mie matter here
  assign unused_mie = ^csr.mie;

  assign ext_p  = ext_s & csr.mie[MIE_MEIE];
  assign tmr_p  = tmr_s & csr.mie[MIE_MTIE];
  assign take   = csr.mstatus[MSTATUS_MIE] & (ext_p | tmr_p);
  assign busy_o = (state != IDLE);

  // mstatus images for trap entry (MPIE<=MIE, MIE<=0) and mret (MIE<=MPIE, MPIE<=1)
  always_comb begin
    status_trap               = csr.mstatus;
    status_trap[MSTATUS_MPIE] = csr.mstatus[MSTATUS_MIE];
    status_trap[MSTATUS_MIE]  = 1'b0;
    status_ret                = csr.mstatus;
    status_ret[MSTATUS_MIE]   = csr.mstatus[MSTATUS_MPIE];
    status_ret[MSTATUS_MPIE]  = 1'b1;
  end

  // Vectored mode adds 4*cause to the aligned base; the sum wraps naturally
  assign tvec_base   = {csr.mtvec[DW-1:2], 2'b00};
  assign tvec_target = (csr.mtvec[1:0] == 2'b01) ?
                       tvec_base + DW'({cause_q[4:0], 2'b00}) : tvec_base;

  // State register plus the pc/cause captured on interrupt acceptance
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        pc_q    <= pc_i;
        cause_q <= ext_p ? CAUSE_EXT_IRQ : CAUSE_TMR_IRQ;
      end
    end
  end

  // Next-state and per-state strobes; data/address buses are zero when idle
  always_comb begin
    state_d       = state;
    accept        = 1'b0;
    csr.csr_we    = 1'b0;
    csr.csr_addr  = '0;
    csr.csr_wdata = '0;
    csr.intr_flag = 1'b0;
    csr.trap_pc   = '0;
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    case (state)
      IDLE: begin
        if (mret_i) begin
          flush_o = 1'b1;
          state_d = RET_STATUS;
        end else if (take && pc_valid_i && !csr_instr_i) begin
          accept  = 1'b1;
          flush_o = 1'b1;
          state_d = SAVE_EPC;
        end
      end
      SAVE_EPC: begin
        csr.csr_we    = 1'b1;
        csr.csr_addr  = ADDRW'(CSR_MEPC);
        csr.csr_wdata = pc_q;
        csr.intr_flag = 1'b1;
        csr.trap_pc   = pc_q;
        flush_o       = 1'b1;
        state_d       = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        csr.csr_we    = 1'b1;
        csr.csr_addr  = ADDRW'(CSR_MCAUSE);
        csr.csr_wdata = DW'(cause_q);
        flush_o       = 1'b1;
        state_d       = SAVE_STATUS;
      end
      SAVE_STATUS: begin
        csr.csr_we    = 1'b1;
        csr.csr_addr  = ADDRW'(CSR_MSTATUS);
        csr.csr_wdata = status_trap;
        flush_o       = 1'b1;
        state_d       = JUMP;
      end
      JUMP: begin
        redirect_o    = 1'b1;
        redirect_pc_o = tvec_target;
        flush_o       = 1'b1;
        state_d       = IDLE;
      end
      RET_STATUS: begin
        csr.csr_we    = 1'b1;
        csr.csr_addr  = ADDRW'(CSR_MSTATUS);
        csr.csr_wdata = status_ret;
        flush_o       = 1'b1;
        state_d       = RET_JUMP;
      end
      RET_JUMP: begin
        redirect_o    = 1'b1;
        redirect_pc_o = csr.mepc;
        flush_o       = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The idle-state flush depends on live inputs; keep it quiet in reset
    if (!rst_i) flush_o = 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Self-checking bench for trap_ctrl with a CSR file model and
//               a transaction-level expectation script.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  localparam int S = 2;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        intr;
    logic [31:0] tpc;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic        busy;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ext, tmr, pcv, csri, mret;
  logic [31:0] pc;
  logic        flush, redirect, busy;
  logic [31:0] redirect_pc;

  trap_ctrl_if #(.DW(32), .ADDRW(12)) bus ();

  trap_ctrl #(.DW(32), .ADDRW(12), .SYNC_STAGES(S)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .ext_irq_i     (ext),
    .tmr_irq_i     (tmr),
    .pc_i          (pc),
    .pc_valid_i    (pcv),
    .csr_instr_i   (csri),
    .mret_i        (mret),
    .csr           (bus),
    .flush_o       (flush),
    .redirect_o    (redirect),
    .redirect_pc_o (redirect_pc),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  out_t        exp_q[$];
  logic [S-1:0] hist_ext, hist_tmr;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [11:0] wl_addr[$];
  logic [31:0] wl_data[$];
  logic        wl_intr[$];
  logic [31:0] rl_pc[$];
  int          rl_cyc[$];
  logic        pend_ms_v, pend_mepc_v;
  logic [31:0] pend_ms, pend_mepc;
  int          w0, r0, c0, cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Per-cycle reference: an idle controller decides what happens now and
  // scripts every later cycle of the sequence it starts.
  task automatic model_cycle();
    out_t act, expv, r;
    logic [31:0] ms, cause;
    logic ext_p, tmr_p, take;
    act.we = bus.csr_we;     act.addr = bus.csr_addr; act.wdata = bus.csr_wdata;
    act.intr = bus.intr_flag; act.tpc = bus.trap_pc;  act.flush = flush;
    act.redir = redirect;    act.rpc = redirect_pc;   act.busy = busy;
    expv = '0;
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      expv = exp_q.pop_front();
    end else begin
      ms    = bus.mstatus;
      ext_p = hist_ext[S-1] && bus.mie[11];
      tmr_p = hist_tmr[S-1] && bus.mie[7];
      take  = ms[3] && (ext_p || tmr_p);
      if (mret) begin
        expv.flush = 1'b1;
        r = '0; r.we = 1'b1; r.addr = 12'h300; r.flush = 1'b1; r.busy = 1'b1;
        r.wdata = (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
        exp_q.push_back(r);
        r = '0; r.redir = 1'b1; r.rpc = bus.mepc; r.flush = 1'b1; r.busy = 1'b1;
        exp_q.push_back(r);
      end else if (take && pcv && !csri) begin
        cause = ext_p ? 32'h8000_000B : 32'h8000_0007;
        expv.flush = 1'b1;
        r = '0; r.we = 1'b1; r.addr = 12'h341; r.wdata = pc; r.intr = 1'b1; r.tpc = pc;
        r.flush = 1'b1; r.busy = 1'b1;
        exp_q.push_back(r);
        r = '0; r.we = 1'b1; r.addr = 12'h342; r.wdata = cause; r.flush = 1'b1; r.busy = 1'b1;
        exp_q.push_back(r);
        r = '0; r.we = 1'b1; r.addr = 12'h300; r.flush = 1'b1; r.busy = 1'b1;
        r.wdata = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
        exp_q.push_back(r);
        r = '0; r.redir = 1'b1; r.flush = 1'b1; r.busy = 1'b1;
        r.rpc = (bus.mtvec & ~32'h3) + ((bus.mtvec[1:0] == 2'b01) ? (cause & 32'd31) * 32'd4 : 32'd0);
        exp_q.push_back(r);
      end
    end
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL cycle_check @%0d: got we=%b a=%h d=%h if=%b tpc=%h fl=%b rd=%b rpc=%h bsy=%b, expected we=%b a=%h d=%h if=%b tpc=%h fl=%b rd=%b rpc=%h bsy=%b",
               cyc, act.we, act.addr, act.wdata, act.intr, act.tpc, act.flush, act.redir, act.rpc, act.busy,
               expv.we, expv.addr, expv.wdata, expv.intr, expv.tpc, expv.flush, expv.redir, expv.rpc, expv.busy);
    end
    if (act.we) begin
      wl_addr.push_back(act.addr);
      wl_data.push_back(act.wdata);
      wl_intr.push_back(act.intr);
      if (act.addr == 12'h300) begin pend_ms = act.wdata; pend_ms_v = 1'b1; end
      if (act.addr == 12'h341) begin pend_mepc = act.wdata; pend_mepc_v = 1'b1; end
    end
    if (act.redir) begin
      rl_pc.push_back(act.rpc);
      rl_cyc.push_back(cyc);
    end
  endtask

  // One clock: check at negedge, record irq levels at posedge, then let the
  // CSR file model publish writes from the previous negedge.
  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      hist_ext = '0;
      hist_tmr = '0;
    end else begin
      hist_ext = {hist_ext[S-2:0], ext};
      hist_tmr = {hist_tmr[S-2:0], tmr};
    end
    #1;
    if (pend_ms_v)   begin bus.mstatus = pend_ms;   pend_ms_v = 1'b0;   end
    if (pend_mepc_v) begin bus.mepc    = pend_mepc; pend_mepc_v = 1'b0; end
  endtask

  task automatic wait_redirects(input int target, input int budget, input string name);
    for (int i = 0; i < budget && rl_pc.size() < target; i++) tick();
    check(name, 32'(rl_pc.size() >= target), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; ext = 1'b0; tmr = 1'b0; pc = '0; pcv = 1'b0; csri = 1'b0; mret = 1'b0;
    bus.mstatus = '0; bus.mie = '0; bus.mtvec = '0; bus.mepc = '0;
    pend_ms_v = 1'b0; pend_mepc_v = 1'b0; pend_ms = '0; pend_mepc = '0;
    hist_ext = '0; hist_tmr = '0;
    repeat (3) tick();
    check("reset_strobes", {27'd0, bus.csr_we, bus.intr_flag, flush, redirect, busy}, 32'd0);
    check("reset_wdata", bus.csr_wdata, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Direct mode, external interrupt
    bus.mstatus = 32'h8; bus.mie = 32'h800; bus.mtvec = 32'h100; pc = 32'h2000; pcv = 1'b1;
    tick();
    w0 = wl_addr.size(); r0 = rl_pc.size(); c0 = cyc; ext = 1'b1;
    wait_redirects(r0 + 1, 30, "direct_redirect");
    check("direct_epc_addr", 32'(wl_addr[w0]), 32'h341);
    check("direct_epc_data", wl_data[w0], 32'h2000);
    check("direct_epc_intr", 32'(wl_intr[w0]), 32'd1);
    check("direct_cause_addr", 32'(wl_addr[w0+1]), 32'h342);
    check("direct_cause_data", wl_data[w0+1], 32'h8000_000B);
    check("direct_status_addr", 32'(wl_addr[w0+2]), 32'h300);
    check("direct_status_data", wl_data[w0+2], 32'h80);
    check("direct_target", rl_pc[r0], 32'h100);
    check("direct_latency", 32'(rl_cyc[r0] - c0), 32'd6);
    ext = 1'b0;
    repeat (4) tick();

    // Vectored mode, both lines high: external wins
    bus.mstatus = 32'h8; bus.mie = 32'h880; bus.mtvec = 32'h101; ext = 1'b1; tmr = 1'b1;
    w0 = wl_addr.size(); r0 = rl_pc.size();
    wait_redirects(r0 + 1, 30, "vec_both_redirect");
    check("vec_both_cause", wl_data[w0+1], 32'h8000_000B);
    check("vec_both_target", rl_pc[r0], 32'h12C);
    ext = 1'b0;
    repeat (4) tick();
    w0 = wl_addr.size(); r0 = rl_pc.size();
    bus.mstatus = 32'h8;
    wait_redirects(r0 + 1, 30, "vec_tmr_redirect");
    check("vec_tmr_cause", wl_data[w0+1], 32'h8000_0007);
    check("vec_tmr_target", rl_pc[r0], 32'h11C);
    tmr = 1'b0;
    repeat (4) tick();

    // Each mask blocks entry; dropping it lets the trap in on that cycle
    for (int m = 0; m < 4; m++) begin
      bus.mstatus = 32'h8; bus.mie = 32'h800; bus.mtvec = 32'h100; pcv = 1'b1; csri = 1'b0;
      case (m)
        0:       bus.mstatus = 32'h0;
        1:       bus.mie = 32'h0;
        2:       pcv = 1'b0;
        default: csri = 1'b1;
      endcase
      ext = 1'b1; w0 = wl_addr.size(); r0 = rl_pc.size();
      repeat (5) tick();
      check("mask_no_write", 32'(wl_addr.size() - w0), 32'd0);
      check("mask_idle", {30'd0, flush, busy}, 32'd0);
      case (m)
        0:       bus.mstatus = 32'h8;
        1:       bus.mie = 32'h800;
        2:       pcv = 1'b1;
        default: csri = 1'b0;
      endcase
      #1;
      check("mask_release_take", 32'(flush), 32'd1);
      wait_redirects(r0 + 1, 20, "mask_redirect");
      ext = 1'b0;
      repeat (4) tick();
    end

    // mret restores MIE from MPIE and returns to mepc
    bus.mstatus = 32'h80; bus.mepc = 32'h2000; bus.mie = 32'h0;
    w0 = wl_addr.size(); r0 = rl_pc.size(); c0 = cyc; mret = 1'b1;
    #1;
    check("mret_flush", 32'(flush), 32'd1);
    tick();
    mret = 1'b0;
    wait_redirects(r0 + 1, 10, "mret_redirect");
    check("mret_status_addr", 32'(wl_addr[w0]), 32'h300);
    check("mret_status_data", wl_data[w0], 32'h88);
    check("mret_target", rl_pc[r0], 32'h2000);
    check("mret_latency", 32'(rl_cyc[r0] - c0), 32'd2);
    repeat (2) tick();

    // mret coinciding with a takeable interrupt goes first
    bus.mstatus = 32'h88; bus.mie = 32'h800; bus.mtvec = 32'h100; pcv = 1'b0; ext = 1'b1;
    repeat (4) tick();
    w0 = wl_addr.size(); r0 = rl_pc.size();
    mret = 1'b1; pcv = 1'b1; pc = 32'h3000;
    tick();
    mret = 1'b0;
    wait_redirects(r0 + 2, 30, "mret_then_trap");
    check("prio_first_addr", 32'(wl_addr[w0]), 32'h300);
    check("prio_second_addr", 32'(wl_addr[w0+1]), 32'h341);
    check("prio_epc_data", wl_data[w0+1], 32'h3000);
    check("prio_mret_target", rl_pc[r0], 32'h2000);
    ext = 1'b0;
    repeat (4) tick();

    // Reset asserted while mcause is being written
    bus.mstatus = 32'h8; bus.mie = 32'h800;
    w0 = wl_addr.size(); r0 = rl_pc.size(); ext = 1'b1;
    for (int i = 0; i < 20 && wl_addr.size() == w0; i++) tick();
    check("rst_reached_epc", 32'(wl_addr.size() - w0), 32'd1);
    rst_n = 1'b0; ext = 1'b0;
    #1;
    check("rst_async_strobes", {27'd0, bus.csr_we, bus.intr_flag, flush, redirect, busy}, 32'd0);
    check("rst_async_addr", 32'(bus.csr_addr), 32'd0);
    check("rst_async_wdata", bus.csr_wdata, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("rst_no_redirect", 32'(rl_pc.size() - r0), 32'd0);
    check("rst_no_more_writes", 32'(wl_addr.size() - w0), 32'd1);
    check("rst_idle", 32'(busy), 32'd0);

    // Held interrupt: one entry until mret re-enables MIE
    bus.mstatus = 32'h8; bus.mie = 32'h800; bus.mtvec = 32'h100; pcv = 1'b1; csri = 1'b0;
    w0 = wl_addr.size(); r0 = rl_pc.size(); ext = 1'b1;
    wait_redirects(r0 + 1, 30, "reentry_first");
    repeat (12) tick();
    cnt = 0;
    for (int i = w0; i < wl_addr.size(); i++) if (wl_addr[i] == 12'h341) cnt++;
    check("reentry_single", 32'(cnt), 32'd1);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    wait_redirects(r0 + 3, 40, "reentry_after_mret");
    cnt = 0;
    for (int i = w0; i < wl_addr.size(); i++) if (wl_addr[i] == 12'h341) cnt++;
    check("reentry_second", 32'(cnt), 32'd2);
    ext = 1'b0;
    repeat (4) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) ext = ~ext;
      if ($urandom_range(0, 15) == 0) tmr = ~tmr;
      pc   = $urandom & ~32'h3;
      pcv  = ($urandom_range(0, 9) != 0);
      csri = ($urandom_range(0, 9) == 0);
      mret = ($urandom_range(0, 29) == 0);
      if (exp_q.size() == 0 && $urandom_range(0, 19) == 0) begin
        bus.mstatus = $urandom;
        bus.mie     = $urandom;
        bus.mtvec   = ($urandom & ~32'h3) | 32'($urandom_range(0, 1));
        bus.mepc    = $urandom;
      end
      tick();
    end
    mret = 1'b0; ext = 1'b0; tmr = 1'b0;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
